// File: rtl/hatch_pkg.sv
// hatch_pkg: shared definitions for the egg-incubator controller.
//   state_t        controller state encoding
//   STAGE_LAST     last growth image before hatching
//   STAGE_HATCHED  display index of the hatched chick
//   STAGE_FAIL     display index used as a blank screen after failure
package hatch_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WARM,
      S_GROW,
      S_COLD,
      S_DONE,
      S_FAIL
   } state_t;

   localparam logic [3:0] STAGE_LAST    = 4'd9;
   localparam logic [3:0] STAGE_HATCHED = 4'd10;
   localparam logic [3:0] STAGE_FAIL    = 4'd11;

endpackage

// File: rtl/hatch_ctrl_tick_gen.sv
// tick_gen: free-running prescaler that turns clk into a one-second tick.
//   clk   in   system clock
//   rst   in   asynchronous active-high reset
//   clr   in   synchronous clear of the count (wins over en)
//   en    in   count enable; the count freezes while low
//   tick  out  high for the one cycle in which the count sits at DIV-1
//              with en set, i.e. on the cycle whose edge wraps the count
module tick_gen #(
   parameter int DIV = 1000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] LAST = PW'(DIV - 1);

   logic [PW-1:0] cnt;

   // Combinational so the controller can act on the same edge that wraps the count.
   assign tick = en && !clr && (cnt == LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= (cnt == LAST) ? '0 : cnt + PW'(1);
      end
   end

endmodule

// File: rtl/hatch_ctrl.sv
// hatch_ctrl: egg-incubation sequencer driving a dot-matrix stage display.
//   clk      in   1 kHz system clock
//   rst      in   asynchronous active-high reset
//   st       in   run enable (level); low returns the block to idle
//   temp     in   1 = temperature OK, 0 = cold
//   num      out  display index: 0..10 growth images, 11 blank (failure)
//   running  out  high while growing or waiting out a cold spell
//   done     out  chick hatched
//   fail     out  egg lost to cold
module hatch_ctrl
   import hatch_pkg::*;
#(
   parameter int TICK_DIV   = 1000,
   parameter int STAGE_SEC  = 3,
   parameter int COLD_LIMIT = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       st,
   input  logic       temp,
   output logic [3:0] num,
   output logic       running,
   output logic       done,
   output logic       fail
);

   localparam int SW = (STAGE_SEC  > 1) ? $clog2(STAGE_SEC)  : 1;
   localparam int CW = (COLD_LIMIT > 1) ? $clog2(COLD_LIMIT) : 1;
   localparam logic [SW-1:0] STG_LAST  = SW'(STAGE_SEC - 1);
   localparam logic [CW-1:0] COLD_LAST = CW'(COLD_LIMIT - 1);

   state_t        state;
   logic [SW-1:0] stg;
   logic [CW-1:0] cold;
   logic          tick;
   logic          pre_clr;
   logic          pre_en;

   // The prescaler only lives while growing or cold. It freezes on a cold
   // edge out of GROW (so a coincident stage wrap is suppressed), but keeps
   // running in COLD to time the cold seconds.
   assign pre_clr = !st || !((state == S_GROW) || (state == S_COLD));
   assign pre_en  = ((state == S_GROW) && temp) || (state == S_COLD);

   tick_gen #(
      .DIV (TICK_DIV)
   ) u_tick (
      .clk  (clk),
      .rst  (rst),
      .clr  (pre_clr),
      .en   (pre_en),
      .tick (tick)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         stg     <= '0;
         cold    <= '0;
         num     <= '0;
         running <= 1'b0;
         done    <= 1'b0;
         fail    <= 1'b0;
      end else if (!st) begin
         state   <= S_IDLE;
         stg     <= '0;
         cold    <= '0;
         num     <= '0;
         running <= 1'b0;
         done    <= 1'b0;
         fail    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: state <= S_WARM;
            S_WARM: begin
               if (temp) begin
                  state   <= S_GROW;
                  stg     <= '0;
                  cold    <= '0;
                  num     <= '0;
                  running <= 1'b1;
               end
            end
            S_GROW: begin
               if (!temp) begin
                  state <= S_COLD;
               end else if (tick) begin
                  if (stg == STG_LAST) begin
                     stg <= '0;
                     if (num == STAGE_LAST) begin
                        num     <= STAGE_HATCHED;
                        state   <= S_DONE;
                        running <= 1'b0;
                        done    <= 1'b1;
                     end else begin
                        num <= num + 4'd1;
                     end
                  end else begin
                     stg <= stg + SW'(1);
                  end
               end
            end
            S_COLD: begin
               // Warmth returning wins; the stage timer resumes where it froze.
               if (temp) begin
                  state <= S_GROW;
                  cold  <= '0;
               end else if (tick) begin
                  if (cold == COLD_LAST) begin
                     state   <= S_FAIL;
                     num     <= STAGE_FAIL;
                     running <= 1'b0;
                     fail    <= 1'b1;
                  end else begin
                     cold <= cold + CW'(1);
                  end
               end
            end
            default: ; // DONE and FAIL hold until st drops
         endcase
      end
   end

endmodule
